// File: rtl/apb_pkg.sv
// Shared types for the APB4 requester bridge: FSM state encoding,
// the PPROT bundle type and the bit positions inside PPROT.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef logic [2:0] apb_prot_t;

  // PPROT[0]: privileged, PPROT[1]: non-secure, PPROT[2]: instruction
  localparam int PROT_PRIV_BIT   = 0;
  localparam int PROT_NONSEC_BIT = 1;
  localparam int PROT_INSTR_BIT  = 2;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slot decoder: the top SEL_BITS address bits select one of
// SLV_COUNT completer slots. Indices with no slot raise dec_err and leave
// the select vector all-zero.
module apb_addr_decoder #(
  parameter int ADDR_WIDTH = 32,
  parameter int SLV_COUNT  = 4,
  parameter int SEL_BITS   = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SLV_COUNT-1:0]  psel,
  output logic                  dec_err
);
  import apb_pkg::*;

  logic [SEL_BITS-1:0] idx;
  logic                unused_low;

  assign idx        = addr[ADDR_WIDTH-1 -: SEL_BITS];
  // Low address bits only travel to PADDR, never into the slot choice.
  assign unused_low = ^addr[ADDR_WIDTH-SEL_BITS-1:0];

  // One-hot select of the addressed slot; no match means a decode error.
  always_comb begin
    psel = '0;
    for (int i = 0; i < SLV_COUNT; i++) begin
      if (idx == SEL_BITS'(i)) psel[i] = 1'b1;
    end
    dec_err = ~|psel;
  end

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 requester: accepts one command at a time on a valid/ready stream,
// runs it as a SETUP/ACCESS transfer on the addressed PSEL slot and returns
// one response per command. Unmapped addresses answer with an error without
// touching the bus.
// Optional feature macro: APB_TIMEOUT_EN adds an ACCESS watchdog that ends
// a stalled transfer with an error after TIMEOUT_CYCLES ACCESS cycles.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLV_COUNT      = 4,
  parameter int SEL_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [SLV_COUNT-1:0]    PSEL,
  output logic                    PENABLE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);
  import apb_pkg::*;

  apb_state_e              state_q;
  logic [SLV_COUNT-1:0]    dec_psel;
  logic                    dec_err;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [SLV_COUNT-1:0]    psel_q;
  logic                    penable_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  apb_prot_t               pprot_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
`endif

  apb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLV_COUNT  (SLV_COUNT),
    .SEL_BITS   (SEL_BITS)
  ) u_dec (
    .addr    (cmd_addr),
    .psel    (dec_psel),
    .dec_err (dec_err)
  );

  // Held low while PRESET is high so no command is taken during reset.
  assign cmd_ready = (state_q == ST_IDLE) && !PRESET;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;

  // Transfer sequencer: IDLE -> SETUP -> ACCESS (wait on PREADY) -> RESP.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (!dec_err) begin
              state_q  <= ST_SETUP;
              paddr_q  <= cmd_addr;
              pwrite_q <= cmd_write;
              psel_q   <= dec_psel;
              // Reads never carry write data or byte strobes onto the bus.
              pwdata_q <= cmd_write ? cmd_wdata : '0;
              pstrb_q  <= cmd_write ? cmd_strb : '0;
              pprot_q  <= cmd_prot;
            end else begin
              state_q     <= ST_RESP;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state_q     <= ST_RESP;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            psel_q      <= '0;
            penable_q   <= 1'b0;
          end
`ifdef APB_TIMEOUT_EN
          // A late PREADY in the last allowed cycle still completes normally.
          else if (tmo_cnt_q == TMO_LAST) begin
            state_q     <= ST_RESP;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb4_master_bridge.md
# apb4_master_bridge

Parametrised APB4 requester that turns a valid/ready command stream into APB4 transfers across `SLV_COUNT` completer slots and returns one response per command. It sits between the bus fabric or test sequencer and the APB interface bundle. It extends plain APB with PSTRB, PPROT, PSLVERR, address-based PSEL decode, a decode-error path and an optional access watchdog.

## Interface
- `ADDR_WIDTH`, 32: PADDR and command address width.
- `DATA_WIDTH`, 32: data width; must be 8, 16 or 32.
- `SLV_COUNT`, 4: number of PSEL lines, 1 to 16.
- `SEL_BITS`, 4: number of top address bits used as the slot index.
- `TIMEOUT_CYCLES`, 256: watchdog limit in ACCESS cycles; only used when `APB_TIMEOUT_EN` is defined.

Ports:
- `PCLK` in 1: clock.
- `PRESET` in 1: synchronous, active-high reset.
- `cmd_valid` in 1; `cmd_ready` out 1: command handshake.
- `cmd_addr` in ADDR_WIDTH; `cmd_write` in 1; `cmd_wdata` in DATA_WIDTH; `cmd_strb` in DATA_WIDTH/8; `cmd_prot` in 3: command payload.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_rdata` out DATA_WIDTH; `rsp_err` out 1: response payload.
- `PADDR` out ADDR_WIDTH; `PWRITE` out 1; `PSEL` out SLV_COUNT; `PENABLE` out 1; `PWDATA` out DATA_WIDTH; `PSTRB` out DATA_WIDTH/8; `PPROT` out 3: APB request signals.
- `PREADY` in 1; `PRDATA` in DATA_WIDTH; `PSLVERR` in 1: APB completion signals.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP.
- Slot index = `cmd_addr[ADDR_WIDTH-1 -: SEL_BITS]`.
- `cmd_ready` = (state == IDLE).
- IDLE, on accepting a command:
  - If index < SLV_COUNT, go to SETUP. Register all payload onto the APB outputs and set PSEL to one-hot of the index.
  - If index ≥ SLV_COUNT, go to RESP with rsp_err=1 and rsp_rdata=0. No PSEL is asserted.
- SETUP goes to ACCESS unconditionally and sets PENABLE=1.
- ACCESS with PREADY=1 goes to RESP.
  - Capture rsp_err = PSLVERR.
  - Capture rsp_rdata = PRDATA on a read, 0 on a write.
  - Clear PSEL and PENABLE.
- ACCESS with PREADY=0 holds. PADDR, PWRITE, PWDATA, PSTRB and PPROT are stable throughout.
- RESP asserts rsp_valid. On rsp_ready, go to IDLE. rsp_rdata and rsp_err are stable while rsp_valid && !rsp_ready.
- PSTRB is driven 0 on reads regardless of cmd_strb.
- PWDATA is driven 0 on reads.
- PADDR and the other request signals hold their last values in IDLE and RESP.

## Timing
- Reset value of every output is 0: cmd_ready=0 during reset, and 1 in the first cycle after reset release.
- Reset mid-transfer drops the transaction with no response. PSEL and PENABLE clear at the reset edge.
- Zero-wait transfer: command accepted at edge T, SETUP in cycle T+1, ACCESS in T+2, rsp_valid in T+3.
- Each wait state adds one cycle.
- With rsp_ready tied high, the next command is accepted in T+4, giving 4 cycles per transfer.
- Decode error: rsp_valid rises in the cycle after acceptance.
- PREADY and PSLVERR are ignored outside ACCESS.
- PRDATA is ignored on writes.

## Configuration
- Macro `APB_TIMEOUT_EN`.
- Defined: a counter, reset on ACCESS entry, increments each ACCESS cycle while PREADY=0.
  - When it reaches TIMEOUT_CYCLES-1 with PREADY still 0, go to RESP with rsp_err=1 and rsp_rdata=0, and drop PSEL and PENABLE.
  - If PREADY=1 arrives in that same cycle, normal completion wins.
- Undefined: no counter, and ACCESS waits indefinitely.

## Structure
- Package `apb_pkg` holds:
  - the state enum `apb_state_e`;
  - `apb_prot_t` (logic [2:0]);
  - localparams for the PROT bit positions.
- Sub-module `apb_addr_decoder`, combinational: address in, one-hot PSEL plus `dec_err` out, parametrised by SLV_COUNT and SEL_BITS.

## Test plan
- Write addr 0x1000_0010, data 0xDEAD_BEEF, strb 0xF, PREADY=1 → PSEL=4'b0010, PSTRB=0xF, PENABLE high for 1 cycle, rsp_err=0, rsp_valid at T+3.
- Read addr 0x2000_0000, PREADY low for 3 cycles, PRDATA=0x1234_5678 → PSEL=4'b0100, request signals stable for 4 ACCESS cycles, rsp_rdata=0x1234_5678, and PSTRB=0 throughout.
- Read with PREADY=1 and PSLVERR=1 → rsp_err=1; a subsequent rsp_ready held low for 5 cycles keeps rsp_valid, rsp_rdata and rsp_err stable.
- Addr 0x5000_0000 with SLV_COUNT=4 → PSEL stays 0, rsp_err=1, rsp_valid at T+1.
- PRESET asserted during ACCESS → PSEL, PENABLE and rsp_valid all 0 next cycle, then cmd_ready=1 after release.
- `APB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, PREADY stuck at 0 → rsp_err=1 after 8 ACCESS cycles, PSEL cleared, and a following command completes normally.
